// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scroller.
// Holds the glyph code set, the matching active-low segment patterns (bit0 = a .. bit6 = g)
// and the all-dark segment value used on reset.
package ssd_pkg;

    localparam int unsigned GLYPH_W = 3;

    typedef enum logic [GLYPH_W-1:0] {
        GLYPH_BLANK = 3'd0,
        GLYPH_H     = 3'd1,
        GLYPH_E     = 3'd2,
        GLYPH_L     = 3'd3,
        GLYPH_O     = 3'd4,
        GLYPH_DASH  = 3'd5,
        GLYPH_P     = 3'd6,
        GLYPH_A     = 3'd7
    } glyph_e;

    // Active-low segments, written g..a
    localparam logic [6:0] SEG_DARK  = 7'h7F;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;

endpackage

// File: rtl/ssd_glyph_dec.sv
// Combinational glyph-code to seven-segment decoder.
// Ports:
//   sym  glyph code (ssd_pkg::glyph_e encoding)
//   seg  active-low segments, bit0 = a .. bit6 = g
module ssd_glyph_dec
    import ssd_pkg::*;
(
    input  logic [GLYPH_W-1:0] sym,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_DARK;
        case (glyph_e'(sym))
            GLYPH_BLANK: seg = SEG_BLANK;
            GLYPH_H:     seg = SEG_H;
            GLYPH_E:     seg = SEG_E;
            GLYPH_L:     seg = SEG_L;
            GLYPH_O:     seg = SEG_O;
            GLYPH_DASH:  seg = SEG_DASH;
            GLYPH_P:     seg = SEG_P;
            GLYPH_A:     seg = SEG_A;
            default:     seg = SEG_DARK;
        endcase
    end

endmodule

// File: rtl/ssd_scroller.sv
// Scrolling-message driver for a bank of seven-segment displays.
// A loaded message of MSG_LEN glyphs is shown through a NUM_DIGITS-wide window whose start
// index rotates on a prescaled tick (run mode) or on a step_i rising edge (paused).
// Ports:
//   CLOCK_50  system clock
//   Clr       asynchronous active-high reset
//   load_i    capture msg_i, rewind window and prescaler (wins over any advance)
//   msg_i     message, glyph j at [j*SYM_W +: SYM_W]
//   run_i     1 = auto scroll, 0 = paused
//   dir_i     0 = window start increments, 1 = decrements
//   speed_i   prescaler period = CLK_DIV >> speed_i
//   step_i    single-step request (level; rising edge used while paused)
//   hex_o     active-low segments, digit k at [k*7 +: 7], digit 0 rightmost
//   pos_o     current window start index
//   tick_o    one-cycle pulse on every advance
module ssd_scroller
    import ssd_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50000000,
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned SYM_W      = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         Clr,
    input  logic                         load_i,
    input  logic [MSG_LEN*SYM_W-1:0]     msg_i,
    input  logic                         run_i,
    input  logic                         dir_i,
    input  logic [1:0]                   speed_i,
    input  logic                         step_i,
    output logic [NUM_DIGITS*7-1:0]      hex_o,
    output logic [$clog2(MSG_LEN)-1:0]   pos_o,
    output logic                         tick_o
);

    localparam int unsigned POS_W = $clog2(MSG_LEN);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]          presc_q, presc_d;
    logic [POS_W-1:0]          pos_q, pos_d;
    logic [MSG_LEN*SYM_W-1:0]  msg_q, msg_d;
    logic                      step_q;
    logic                      tick_q, tick_d;
    logic [NUM_DIGITS*7-1:0]   hex_q, hex_d;

    logic [CNT_W-1:0]          tc;
    logic                      tick;
    logic                      step_rise;
    logic                      advance;

    // CLK_DIV-1 always fits in CNT_W bits, so the truncation is lossless.
    assign tc = CNT_W'((CLK_DIV >> speed_i) - 32'd1);

    always_comb begin
        tick      = run_i & (presc_q >= tc);
        step_rise = step_i & ~step_q;
        advance   = tick | (step_rise & ~run_i);

        presc_d = presc_q;
        pos_d   = pos_q;
        msg_d   = msg_q;
        tick_d  = 1'b0;

        if (load_i) begin
            msg_d   = msg_i;
            pos_d   = '0;
            presc_d = '0;
        end else begin
            if (run_i) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end
            if (advance) begin
                tick_d = 1'b1;
                if (!dir_i) begin
                    pos_d = (pos_q == POS_W'(MSG_LEN - 1)) ? '0 : pos_q + 1'b1;
                end else begin
                    pos_d = (pos_q == '0) ? POS_W'(MSG_LEN - 1) : pos_q - 1'b1;
                end
            end
        end
    end

    // Window: digit k shows msg[(pos + NUM_DIGITS-1-k) mod MSG_LEN]. Both addends are below
    // MSG_LEN, so one conditional subtract performs the wrap.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        localparam int unsigned OFS = NUM_DIGITS - 1 - k;

        logic [POS_W:0]     sum;
        logic [POS_W-1:0]   idx;
        logic [SYM_W-1:0]   sym;
        logic [6:0]         seg;

        assign sum = {1'b0, pos_q} + (POS_W+1)'(OFS);
        assign idx = (sum >= (POS_W+1)'(MSG_LEN)) ? POS_W'(sum - (POS_W+1)'(MSG_LEN))
                                                  : sum[POS_W-1:0];
        assign sym = msg_q[idx*SYM_W +: SYM_W];

        ssd_glyph_dec u_dec (
            .sym (sym),
            .seg (seg)
        );

        assign hex_d[k*7 +: 7] = seg;
    end

    always_ff @(posedge CLOCK_50 or posedge Clr) begin
        if (Clr) begin
            presc_q <= '0;
            pos_q   <= '0;
            msg_q   <= '0;
            step_q  <= 1'b0;
            tick_q  <= 1'b0;
            hex_q   <= {NUM_DIGITS{SEG_DARK}};
        end else begin
            presc_q <= presc_d;
            pos_q   <= pos_d;
            msg_q   <= msg_d;
            step_q  <= step_i;
            tick_q  <= tick_d;
            // Decoded from the current registers, so it trails pos_o by one cycle.
            hex_q   <= hex_d;
        end
    end

    assign hex_o  = hex_q;
    assign pos_o  = pos_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_ssd_scroller.sv
// Scoreboard bench for ssd_scroller with CLK_DIV = 8, MSG_LEN = 6, NUM_DIGITS = 4.
module tb_ssd_scroller;

    localparam int CLK_DIV = 8;
    localparam int ML      = 6;
    localparam int ND      = 4;

    typedef struct packed {
        logic [2:0]  pos;
        logic        tick;
        logic [27:0] hex;
    } exp_t;

    logic        clk;
    logic        Clr;
    logic        load_i;
    logic [17:0] msg_i;
    logic        run_i;
    logic        dir_i;
    logic [1:0]  speed_i;
    logic        step_i;
    logic [27:0] hex_o;
    logic [2:0]  pos_o;
    logic        tick_o;

    int n_vec = 0;
    int n_err = 0;

    exp_t exp_q[$];

    // Reference model state
    int m_msg[ML];
    int m_pos;
    int m_presc;
    bit m_step;

    localparam logic [17:0] HELLO = {3'd5, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1};

    ssd_scroller #(
        .CLK_DIV    (CLK_DIV),
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .SYM_W      (3)
    ) dut (
        .CLOCK_50 (clk),
        .Clr      (Clr),
        .load_i   (load_i),
        .msg_i    (msg_i),
        .run_i    (run_i),
        .dir_i    (dir_i),
        .speed_i  (speed_i),
        .step_i   (step_i),
        .hex_o    (hex_o),
        .pos_o    (pos_o),
        .tick_o   (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int g);
        case (g)
            1:       return 7'b0001001;
            2:       return 7'b0000110;
            3:       return 7'b1000111;
            4:       return 7'b1000000;
            5:       return 7'b0111111;
            6:       return 7'b0001100;
            7:       return 7'b0001000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] window_hex();
        logic [27:0] h;
        for (int k = 0; k < ND; k++) begin
            h[k*7 +: 7] = seg_of(m_msg[(m_pos + ND - 1 - k) % ML]);
        end
        return h;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Model: advances on every rising clock edge from the inputs the DUT also sampled.
    always @(posedge clk) begin
        exp_t e;
        int   tc;
        bit   adv;
        if (Clr) begin
            m_pos   = 0;
            m_presc = 0;
            m_step  = 0;
            for (int j = 0; j < ML; j++) m_msg[j] = 0;
            e.pos  = '0;
            e.tick = 1'b0;
            e.hex  = '1;
        end else begin
            e.hex = window_hex();
            tc    = (CLK_DIV >> speed_i) - 1;
            adv   = 0;
            if (load_i) begin
                for (int j = 0; j < ML; j++) m_msg[j] = int'(msg_i[j*3 +: 3]);
                m_pos   = 0;
                m_presc = 0;
            end else begin
                if (run_i) begin
                    if (m_presc >= tc) begin
                        m_presc = 0;
                        adv     = 1;
                    end else begin
                        m_presc++;
                    end
                end else if (step_i && !m_step) begin
                    adv = 1;
                end
                if (adv) m_pos = dir_i ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML;
            end
            m_step = step_i;
            e.pos  = 3'(m_pos);
            e.tick = adv;
        end
        exp_q.push_back(e);
    end

    // Monitor: one expected entry per clock, compared shortly after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("pos_o", 32'(pos_o), 32'(e.pos));
            check("tick_o", 32'(tick_o), 32'(e.tick));
            check("hex_o", 32'(hex_o), 32'(e.hex));
        end
    end

    task automatic load_msg(input logic [17:0] m);
        @(negedge clk);
        load_i = 1'b1;
        msg_i  = m;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    task automatic wait_presc(input int val);
        bit found = 0;
        for (int i = 0; i < 32 && !found; i++) begin
            @(negedge clk);
            if (m_presc == val) found = 1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_presc: got timeout, expected prescaler %0d", val);
        end
    endtask

    initial begin
        int ticks;
        Clr     = 1'b1;
        load_i  = 1'b0;
        msg_i   = '0;
        run_i   = 1'b0;
        dir_i   = 1'b0;
        speed_i = 2'd0;
        step_i  = 1'b0;
        repeat (3) @(negedge clk);
        Clr = 1'b0;

        // Load and run forward at full period
        run_i = 1'b1;
        load_msg(HELLO);
        @(posedge clk);
        #2;
        check("hex_after_load", 32'(hex_o), 32'({7'b0001001, 7'b0000110, 7'b1000111, 7'b1000111}));
        repeat (60) @(negedge clk);

        // Reverse from wherever pos is; then speed up with prescaler at 5
        dir_i = 1'b1;
        repeat (30) @(negedge clk);
        wait_presc(5);
        speed_i = 2'd2;
        @(negedge clk);
        check("speed_change_tick", 32'(tick_o), 32'd1);
        repeat (20) @(negedge clk);

        // Reset mid-run
        Clr = 1'b1;
        #1;
        check("clr_hex", 32'(hex_o), 32'h0FFF_FFFF);
        check("clr_pos", 32'(pos_o), 32'd0);
        check("clr_tick", 32'(tick_o), 32'd0);
        repeat (2) @(negedge clk);
        Clr = 1'b0;

        // Pause and hold step high: one advance only
        load_msg(HELLO);
        run_i   = 1'b0;
        dir_i   = 1'b0;
        speed_i = 2'd0;
        @(negedge clk);
        step_i = 1'b1;
        ticks  = 0;
        repeat (11) begin
            @(negedge clk);
            if (tick_o) ticks++;
        end
        step_i = 1'b0;
        check("step_held_ticks", 32'(ticks), 32'd1);

        // Step toggling while running is ignored (model checks pos/tick)
        run_i = 1'b1;
        repeat (24) begin
            @(negedge clk);
            step_i = ~step_i;
        end
        step_i = 1'b0;

        // Load on the terminal-count cycle
        wait_presc(7);
        load_i = 1'b1;
        msg_i  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
        @(negedge clk);
        load_i = 1'b0;
        check("load_prio_pos", 32'(pos_o), 32'd0);
        check("load_prio_tick", 32'(tick_o), 32'd0);
        repeat (4) @(negedge clk);

        // Window wrap at pos 4
        run_i = 1'b0;
        load_msg(HELLO);
        repeat (4) begin
            @(negedge clk);
            step_i = 1'b1;
            @(negedge clk);
            step_i = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("wrap_pos", 32'(pos_o), 32'd4);
        check("wrap_hex", 32'(hex_o), 32'({7'b1000000, 7'b0111111, 7'b0001001, 7'b0000110}));

        // Randomized traffic
        repeat (3000) begin
            @(negedge clk);
            Clr    = ($urandom_range(499) == 0);
            load_i = ($urandom_range(63) == 0);
            msg_i  = 18'($urandom);
            if ($urandom_range(15) == 0) run_i = ~run_i;
            if ($urandom_range(15) == 0) dir_i = ~dir_i;
            if ($urandom_range(15) == 0) speed_i = 2'($urandom);
            step_i = ($urandom_range(2) == 0);
        end
        @(negedge clk);
        Clr    = 1'b0;
        load_i = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
